// File: rtl/rd_packer_if.sv
// FIFO read-port and packed-beat stream bundle for rd_packer.
// master = the packer (drives rinc and the beat); slave = FIFO/consumer side.
interface rd_packer_if #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
);
  logic [DSIZE-1:0]       rdata;
  logic                   rempty;
  logic                   rinc;
  logic                   flush;
  logic [DSIZE*RATIO-1:0] m_data;
  logic [RATIO-1:0]       m_keep;
  logic                   m_last;
  logic                   m_valid;
  logic                   m_ready;

  modport master (
    input  rdata, rempty, flush, m_ready,
    output rinc, m_data, m_keep, m_last, m_valid
  );

  modport slave (
    output rdata, rempty, flush, m_ready,
    input  rinc, m_data, m_keep, m_last, m_valid
  );
endinterface

// File: rtl/rd_packer.sv
// Packs RATIO FIFO words into one beat, 1 cycle after the final pop; stalls popping the closing word while the output is held.
// Flush (or the idle timeout under RD_PACK_TMO_EN) emits a partial beat with m_last=1.
module rd_packer #(
  parameter int DSIZE      = 8,
  parameter int RATIO      = 4,
  parameter int TMO_CYCLES = 16
) (
  input  logic       rclk,
  input  logic       rrst,
  rd_packer_if.master bus
);
  localparam int CW = $clog2(RATIO + 1);
  localparam int AW = DSIZE * (RATIO - 1);
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  if (RATIO < 2) begin : g_bad_ratio
    $error("rd_packer: RATIO must be >= 2");
  end
  if (TMO_CYCLES < 1) begin : g_bad_tmo
    $error("rd_packer: TMO_CYCLES must be >= 1");
  end

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic                   flush_pending_q, flush_pending_d;
  logic [DSIZE*RATIO-1:0] m_data_q, m_data_d;
  logic [RATIO-1:0]       m_keep_q, m_keep_d;
  logic                   m_last_q, m_last_d;
  logic                   m_valid_q, m_valid_d;
  logic                   out_free;
  logic                   pop;
  logic                   tmo_fire;

  assign out_free = !m_valid_q || bus.m_ready;
  // The closing word of a beat is only taken when the output register can accept it.
  assign pop = !rrst && !bus.rempty && !flush_pending_q &&
               ((cnt_q < LAST_LANE) || out_free);

  assign bus.rinc    = pop;
  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_valid = m_valid_q;

`ifdef RD_PACK_TMO_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d   = idle_q;
    tmo_fire = 1'b0;
    if (pop || bus.flush) begin
      idle_d = '0;
    end else if ((cnt_q != '0) && bus.rempty && !flush_pending_q) begin
      if (idle_q == TW'(TMO_CYCLES - 1)) begin
        tmo_fire = 1'b1;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    cnt_d           = cnt_q;
    acc_d           = acc_q;
    flush_pending_d = flush_pending_q;
    m_data_d        = m_data_q;
    m_keep_d        = m_keep_q;
    m_last_d        = m_last_q;
    m_valid_d       = m_valid_q;

    if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    if (pop) begin
      if (cnt_q == LAST_LANE) begin
        // Closing word goes straight to the top lane; a same-cycle flush just marks it last.
        m_data_d  = {bus.rdata, acc_q};
        m_keep_d  = '1;
        m_last_d  = bus.flush;
        m_valid_d = 1'b1;
        cnt_d     = '0;
      end else begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (cnt_q == CW'(k)) begin
            acc_d[k*DSIZE +: DSIZE] = bus.rdata;
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (bus.flush) begin
          flush_pending_d = 1'b1;
        end
      end
    end else if (flush_pending_q && out_free) begin
      flush_pending_d = 1'b0;
      if (cnt_q != '0) begin
        // Lanes above cnt may hold words from an earlier beat, so mask them out.
        m_data_d = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
          if (CW'(k) < cnt_q) begin
            m_data_d[k*DSIZE +: DSIZE] = acc_q[k*DSIZE +: DSIZE];
          end
        end
        for (int k = 0; k < RATIO; k++) begin
          m_keep_d[k] = (CW'(k) < cnt_q);
        end
        m_last_d  = 1'b1;
        m_valid_d = 1'b1;
        cnt_d     = '0;
      end
    end else if (bus.flush || tmo_fire) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q           <= '0;
      acc_q           <= '0;
      flush_pending_q <= 1'b0;
      m_data_q        <= '0;
      m_keep_q        <= '0;
      m_last_q        <= 1'b0;
      m_valid_q       <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      flush_pending_q <= flush_pending_d;
      m_data_q        <= m_data_d;
      m_keep_q        <= m_keep_d;
      m_last_q        <= m_last_d;
      m_valid_q       <= m_valid_d;
    end
  end
endmodule
